// File: rtl/welcome_menu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// welcome_menu_ctrl_pkg
// Shared types and constants for the welcome/title screen sequencer.
//   menu_state_e   : sequencer states (MENU, CONFIRM, ACK, START)
//   DEF_*_FRAMES   : default frame counts for the phase generators
//   SEL_PLAY/ACK   : encoding of the menu selection
//   KEY_*          : bit positions of the keys in the packed key vector
//   cnt_width()    : counter width needed to count 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package welcome_menu_ctrl_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        CONFIRM = 2'd1,
        ACK     = 2'd2,
        START   = 2'd3
    } menu_state_e;

    localparam int DEF_BLINK_FRAMES   = 32;
    localparam int DEF_FAST_FRAMES    = 4;
    localparam int DEF_HINT_FRAMES    = 64;
    localparam int DEF_FIRE_FRAMES    = 8;
    localparam int DEF_KONG_FRAMES    = 32;
    localparam int DEF_DEB_FRAMES     = 2;
    localparam int DEF_CONFIRM_FRAMES = 48;

    localparam logic SEL_PLAY = 1'b0;
    localparam logic SEL_ACK  = 1'b1;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_ENTER = 2;
    localparam int KEY_BACK  = 3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/welcome_menu_ctrl_frame_toggle.sv
// -----------------------------------------------------------------------------
// welcome_menu_ctrl_frame_toggle
// Divides frame ticks by N: the counter advances on each tick, and when it
// wraps from N-1 to 0 the phase output flips. N=1 flips on every tick.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle frame pulse
//   clr        : synchronous clear of counter and phase (wins over tick)
//   phase      : registered toggle output
// -----------------------------------------------------------------------------
module welcome_menu_ctrl_frame_toggle
    import welcome_menu_ctrl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    output logic phase
);

    localparam int            W    = cnt_width(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/welcome_menu_ctrl.sv
// -----------------------------------------------------------------------------
// welcome_menu_ctrl
// Title-screen sequencer: conditions the raw keys, owns the PLAY/ACK menu
// selection, produces blink/hint/fire/kong phases from frame ticks and runs
// the launch handshake toward the game core.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_tick          : one-cycle pulse per frame
//   key_up/down/enter/back : raw asynchronous key levels, active high
//   game_ack            : game core accepts the start request
//   sel                 : 0 = PLAY highlighted, 1 = ACK highlighted
//   play_vis, ack_vis   : menu item visibility (combinational from registers)
//   hint_vis            : hint text visible
//   fire_phase, kong_phase : animation phases
//   show_ack            : acknowledgement page active
//   game_start          : start request to the game core
//   state_dbg           : current sequencer state, for observation
//
// Start handshake: game_start acts as "valid" and game_ack as "ready".
// game_start rises on entry to START and holds until a cycle in which
// game_ack is sampled high; that cycle completes the transfer, so
// game_start is low from the next cycle on. game_ack is ignored elsewhere.
// -----------------------------------------------------------------------------
module welcome_menu_ctrl
    import welcome_menu_ctrl_pkg::*;
#(
    parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES,
    parameter int FAST_FRAMES    = DEF_FAST_FRAMES,
    parameter int HINT_FRAMES    = DEF_HINT_FRAMES,
    parameter int FIRE_FRAMES    = DEF_FIRE_FRAMES,
    parameter int KONG_FRAMES    = DEF_KONG_FRAMES,
    parameter int DEB_FRAMES     = DEF_DEB_FRAMES,
    parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_enter,
    input  logic        key_back,
    input  logic        game_ack,
    output logic        sel,
    output logic        play_vis,
    output logic        ack_vis,
    output logic        hint_vis,
    output logic        fire_phase,
    output logic        kong_phase,
    output logic        show_ack,
    output logic        game_start,
    output menu_state_e state_dbg
);

    localparam int                CONF_W    = cnt_width(CONFIRM_FRAMES);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_FRAMES - 1);

    // ---------------------------------------------------------------------
    // Key conditioning: 2-FF synchronizer, then a history of the synced
    // level sampled on frame ticks. The debounced level only moves once the
    // last DEB_FRAMES samples agree; the press event is its rising edge.
    // ---------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_ev;

    assign key_raw = {key_back, key_enter, key_down, key_up};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
        logic                  sync1_q, sync2_q;
        logic [DEB_FRAMES-1:0] hist_q, hist_d;
        logic                  deb_q, deb_d;
        logic                  deb_dly_q;

        always_comb begin
            hist_d = hist_q;
            deb_d  = deb_q;
            if (frame_tick) begin
                hist_d    = hist_q << 1;
                hist_d[0] = sync2_q;
                if (&hist_d) begin
                    deb_d = 1'b1;
                end else if (~|hist_d) begin
                    deb_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                hist_q    <= '0;
                deb_q     <= 1'b0;
                deb_dly_q <= 1'b0;
            end else begin
                sync1_q   <= key_raw[k];
                sync2_q   <= sync1_q;
                hist_q    <= hist_d;
                deb_q     <= deb_d;
                deb_dly_q <= deb_q;
            end
        end

        // Single-cycle pulse: high only in the cycle after deb_q rises.
        assign key_ev[k] = deb_q & ~deb_dly_q;
    end

    logic ev_up, ev_down, ev_enter, ev_back;
    assign ev_up    = key_ev[KEY_UP];
    assign ev_down  = key_ev[KEY_DOWN];
    assign ev_enter = key_ev[KEY_ENTER];
    assign ev_back  = key_ev[KEY_BACK];

    // ---------------------------------------------------------------------
    // Phase generators
    // ---------------------------------------------------------------------
    logic blink_slow, blink_fast, hint_ph, fire_ph, kong_ph;
    logic fast_clr;

    welcome_menu_ctrl_frame_toggle #(.N(BLINK_FRAMES)) u_blink_slow (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .clr(1'b0), .phase(blink_slow)
    );

    // Restarted on entry to CONFIRM so the confirmation blink always begins
    // with the selected item hidden for a full fast half-period.
    welcome_menu_ctrl_frame_toggle #(.N(FAST_FRAMES)) u_blink_fast (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .clr(fast_clr), .phase(blink_fast)
    );

    welcome_menu_ctrl_frame_toggle #(.N(HINT_FRAMES)) u_hint (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .clr(1'b0), .phase(hint_ph)
    );

    welcome_menu_ctrl_frame_toggle #(.N(FIRE_FRAMES)) u_fire (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .clr(1'b0), .phase(fire_ph)
    );

    welcome_menu_ctrl_frame_toggle #(.N(KONG_FRAMES)) u_kong (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .clr(1'b0), .phase(kong_ph)
    );

    // ---------------------------------------------------------------------
    // Sequencer FSM: state register
    // ---------------------------------------------------------------------
    menu_state_e       state_q, state_d;
    logic              sel_q, sel_d;
    logic              choice_q, choice_d;
    logic [CONF_W-1:0] conf_cnt_q, conf_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MENU;
            sel_q      <= SEL_PLAY;
            choice_q   <= SEL_PLAY;
            conf_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            choice_q   <= choice_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        choice_d   = choice_q;
        conf_cnt_d = conf_cnt_q;
        fast_clr   = 1'b0;
        case (state_q)
            MENU: begin
                // Enter takes priority; opposing up/down cancel each other.
                if (ev_enter) begin
                    state_d    = CONFIRM;
                    choice_d   = sel_q;
                    conf_cnt_d = '0;
                    fast_clr   = 1'b1;
                end else if (ev_up && !ev_down) begin
                    sel_d = SEL_PLAY;
                end else if (ev_down && !ev_up) begin
                    sel_d = SEL_ACK;
                end
            end
            CONFIRM: begin
                if (frame_tick) begin
                    if (conf_cnt_q == CONF_LAST) begin
                        conf_cnt_d = '0;
                        state_d    = (choice_q == SEL_PLAY) ? START : ACK;
                    end else begin
                        conf_cnt_d = conf_cnt_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (ev_back || ev_enter) begin
                    state_d = MENU;
                    sel_d   = SEL_ACK;
                end
            end
            START: begin
                if (game_ack) begin
                    state_d = MENU;
                    sel_d   = SEL_PLAY;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM: outputs (decoded from registers only)
    // ---------------------------------------------------------------------
    logic blink;

    always_comb begin
        blink      = (state_q == CONFIRM) ? blink_fast : blink_slow;
        sel        = sel_q;
        play_vis   = (sel_q == SEL_ACK) | blink;
        ack_vis    = (sel_q == SEL_PLAY) | blink;
        hint_vis   = ~hint_ph;
        fire_phase = fire_ph;
        kong_phase = kong_ph;
        show_ack   = (state_q == ACK);
        game_start = (state_q == START);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_welcome_menu_ctrl.sv
module tb_welcome_menu_ctrl;
    import welcome_menu_ctrl_pkg::*;

    localparam int BLINK = 32;
    localparam int FAST  = 4;
    localparam int HINT  = 64;
    localparam int FIRE  = 8;
    localparam int KONG  = 32;
    localparam int DEB   = 2;
    localparam int CONF  = 48;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, key_back = 1'b0;
    logic game_ack = 1'b0;
    logic sel, play_vis, ack_vis, hint_vis, fire_phase, kong_phase, show_ack, game_start;
    menu_state_e state_dbg;

    always #5 clk = ~clk;

    welcome_menu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .key_up(key_up), .key_down(key_down), .key_enter(key_enter), .key_back(key_back),
        .game_ack(game_ack),
        .sel(sel), .play_vis(play_vis), .ack_vis(ack_vis), .hint_vis(hint_vis),
        .fire_phase(fire_phase), .kong_phase(kong_phase), .show_ack(show_ack),
        .game_start(game_start), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // Frame-level view: phases are ticks-since-reset divided by the period,
    // the debounced level follows the run length of identical samples.
    int          m_frames, m_fast, m_conf;
    menu_state_e m_state;
    logic        m_sel, m_choice;
    logic        m_deb[4];
    logic        m_last[4];
    int          m_run[4];

    task automatic model_reset();
        m_frames = 0; m_fast = 0; m_conf = 0;
        m_state = MENU; m_sel = 1'b0; m_choice = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_deb[k] = 1'b0; m_last[k] = 1'b0; m_run[k] = DEB;
        end
    endtask

    task automatic model_tick(input logic [3:0] keys);
        logic ev[4];
        m_frames++;
        m_fast++;
        for (int k = 0; k < 4; k++) begin
            if (keys[k] == m_last[k]) m_run[k]++;
            else begin m_last[k] = keys[k]; m_run[k] = 1; end
            ev[k] = 1'b0;
            if (m_run[k] >= DEB && m_deb[k] != m_last[k]) begin
                ev[k] = m_last[k];
                m_deb[k] = m_last[k];
            end
        end
        if (m_state == CONFIRM) begin
            m_conf++;
            if (m_conf == CONF) m_state = m_choice ? ACK : START;
        end
        // key events land one cycle after the tick, i.e. in the updated state
        if (m_state == MENU) begin
            if (ev[2]) begin
                m_state = CONFIRM; m_choice = m_sel; m_conf = 0; m_fast = 0;
            end else if (ev[0] && !ev[1]) m_sel = 1'b0;
            else if (ev[1] && !ev[0]) m_sel = 1'b1;
        end else if (m_state == ACK) begin
            if (ev[3] || ev[2]) begin m_state = MENU; m_sel = 1'b1; end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input string what, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0b expected %0b (t=%0t)", tag, what, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input menu_state_e act, input menu_state_e exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.state: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic blink;
        blink = (m_state == CONFIRM) ? (((m_fast / FAST) % 2) == 1)
                                     : (((m_frames / BLINK) % 2) == 1);
        chk(tag, "sel", sel, m_sel);
        chk(tag, "play_vis", play_vis, m_sel | blink);
        chk(tag, "ack_vis", ack_vis, !m_sel | blink);
        chk(tag, "hint_vis", hint_vis, ((m_frames / HINT) % 2) == 0);
        chk(tag, "fire_phase", fire_phase, ((m_frames / FIRE) % 2) == 1);
        chk(tag, "kong_phase", kong_phase, ((m_frames / KONG) % 2) == 1);
        chk(tag, "show_ack", show_ack, m_state == ACK);
        chk(tag, "game_start", game_start, m_state == START);
        chk_state(tag, state_dbg, m_state);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_keys(input logic [3:0] k);
        {key_back, key_enter, key_down, key_up} = k;
    endtask

    task automatic tick_frame(input string tag);
        repeat (3) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        model_tick({key_back, key_enter, key_down, key_up});
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 game_ack = 1'b1;
        @(posedge clk);
        #1 game_ack = 1'b0;
        if (m_state == START) begin m_state = MENU; m_sel = 1'b0; end
        @(negedge clk);
        check_outputs("ack_pulse");
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  keys;     // {back, enter, down, up}
        int          frames;
        logic        exp_sel;
        menu_state_e exp_state;
    } step_t;

    step_t steps[$];

    function automatic step_t mk(input logic [3:0] k, input int f, input logic s, input menu_state_e st);
        step_t r;
        r.keys = k; r.frames = f; r.exp_sel = s; r.exp_state = st;
        return r;
    endfunction

    initial begin
        steps.push_back(mk(4'b0010,  3, 1'b1, MENU));     // down held: one event
        steps.push_back(mk(4'b0000,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0001,  1, 1'b1, MENU));     // 1-frame up glitch
        steps.push_back(mk(4'b0000,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0100,  2, 1'b1, CONFIRM));  // enter with sel=1
        steps.push_back(mk(4'b0000, 46, 1'b1, CONFIRM));
        steps.push_back(mk(4'b0000,  2, 1'b1, ACK));      // 48th frame
        steps.push_back(mk(4'b1000,  2, 1'b1, MENU));     // back
        steps.push_back(mk(4'b0000,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0001,  2, 1'b0, MENU));     // up
        steps.push_back(mk(4'b0000,  2, 1'b0, MENU));
        steps.push_back(mk(4'b0011,  2, 1'b0, MENU));     // up+down, sel=0
        steps.push_back(mk(4'b0000,  2, 1'b0, MENU));
        steps.push_back(mk(4'b0010,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0000,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0011,  2, 1'b1, MENU));     // up+down, sel=1
        steps.push_back(mk(4'b0000,  2, 1'b1, MENU));
        steps.push_back(mk(4'b0001,  2, 1'b0, MENU));
        steps.push_back(mk(4'b0000,  2, 1'b0, MENU));
        steps.push_back(mk(4'b0110,  2, 1'b0, CONFIRM));  // enter+down: old sel
        steps.push_back(mk(4'b0000,  2, 1'b0, CONFIRM));
        steps.push_back(mk(4'b0010,  3, 1'b0, CONFIRM));  // down ignored
        steps.push_back(mk(4'b0000, 42, 1'b0, CONFIRM));
        steps.push_back(mk(4'b0000,  1, 1'b0, START));
        steps.push_back(mk(4'b0000,  3, 1'b0, START));

        // reset
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset_release");

        // free-running phases, no keys
        for (int i = 0; i < 70; i++) tick_frame("idle");

        // directed steps
        for (int i = 0; i < steps.size(); i++) begin
            set_keys(steps[i].keys);
            for (int f = 0; f < steps[i].frames; f++) tick_frame("step");
            chk("table", "sel", sel, steps[i].exp_sel);
            chk_state("table", state_dbg, steps[i].exp_state);
        end

        // start handshake
        chk("hs", "game_start_held", game_start, 1'b1);
        @(posedge clk);
        #1 game_ack = 1'b1;
        @(negedge clk);
        chk("hs", "game_start_before_ack", game_start, 1'b1);
        @(posedge clk);
        #1 game_ack = 1'b0;
        @(negedge clk);
        chk("hs", "game_start_after_ack", game_start, 1'b0);
        chk("hs", "sel_after_ack", sel, 1'b0);
        chk_state("hs", state_dbg, MENU);
        m_state = MENU; m_sel = 1'b0;
        pulse_ack();   // ack outside START has no effect
        tick_frame("post_ack");

        // reset while in START
        set_keys(4'b0100);
        repeat (2) tick_frame("to_confirm");
        set_keys(4'b0000);
        repeat (CONF) tick_frame("to_start");
        chk("rst_mid", "game_start_pre", game_start, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid", "game_start_async", game_start, 1'b0);
        model_reset();
        check_outputs("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick_frame("after_rst");

        // randomized stimulus against the model
        for (int i = 0; i < 80; i++) begin
            logic [3:0] k;
            for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 3) == 0);
            set_keys(k);
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) tick_frame("rand");
            if ($urandom_range(0, 3) == 0) pulse_ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
